// File: rtl/brew_pkg.sv
// Shared types and constants for the drink sequencer: state codes,
// ingredient indices and the fixed recipe duration table.
package brew_pkg;

    localparam int unsigned NUM_INGR    = 5;
    localparam int unsigned NUM_RECIPES = 5;

    localparam logic [2:0] ING_WATER  = 3'd0;
    localparam logic [2:0] ING_COFFEE = 3'd1;
    localparam logic [2:0] ING_SUGAR  = 3'd2;
    localparam logic [2:0] ING_MILK   = 3'd3;
    localparam logic [2:0] ING_CHOC   = 3'd4;

    localparam logic [2:0] STEP_DONE  = 3'd6;

    // State codes double as the displayed step index.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WATER  = 3'd1,
        ST_COFFEE = 3'd2,
        ST_SUGAR  = 3'd3,
        ST_MILK   = 3'd4,
        ST_CHOC   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Seconds per ingredient, order W, C, S, M, Ch.
    localparam logic [0:NUM_RECIPES-1][0:NUM_INGR-1][1:0] RECIPE = '{
        '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0},  // espresso
        '{2'd3, 2'd1, 2'd1, 2'd0, 2'd0},  // americano
        '{2'd1, 2'd1, 2'd1, 2'd3, 2'd0},  // latte
        '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2},  // mocha
        '{2'd1, 2'd2, 2'd0, 2'd2, 2'd1}   // cappuccino
    };

    // Table lookup that yields 0 for any out-of-range index.
    function automatic logic [1:0] recipe_dur(input logic [2:0] drink, input logic [2:0] ing);
        if (drink < 3'(NUM_RECIPES) && ing < 3'(NUM_INGR))
            return RECIPE[drink][ing];
        return 2'd0;
    endfunction

endpackage

// File: rtl/brew_sequencer_step_timer.sv
// One-second prescaler plus a 2-bit seconds counter; strobes expire on the
// last cycle of a step lasting target seconds (immediately if target is 0).
module step_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] target,
    output logic       expire
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [PW-1:0] prescale;
    logic [1:0]    seconds;
    logic          wrap;

    assign wrap = (prescale == PRE_LAST);

    // Expire on the wrap that completes the final second of the step.
    always_comb begin
        expire = 1'b0;
        if (enable) begin
            if (target == 2'd0)
                expire = 1'b1;
            else if (wrap && seconds == (target - 2'd1))
                expire = 1'b1;
        end
    end

    // Prescaler and seconds counter, cleared on every step entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            seconds  <= '0;
        end else if (clear) begin
            prescale <= '0;
            seconds  <= '0;
        end else if (enable) begin
            if (wrap) begin
                prescale <= '0;
                if (seconds != 2'd3)
                    seconds <= seconds + 2'd1;
            end else begin
                prescale <= prescale + PRE_ONE;
            end
        end
    end

endmodule

// File: rtl/brew_sequencer.sv
// Sequences one paid drink order through the ingredient valves using the
// recipe table, one valve at a time, with abort and reject reporting.
module brew_sequencer
    import brew_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned NUM_TYPES     = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] coffee_type,
    input  logic       paid,
    input  logic       abort,
    output logic       ready,
    output logic       water,
    output logic       coffee,
    output logic       sugar,
    output logic       milk,
    output logic       chocolate,
    output logic [2:0] step,
    output logic       finished,
    output logic       rejected,
    output logic       aborted
);

    localparam logic [3:0] TYPE_LIMIT = 4'(NUM_TYPES);

    state_t     state, state_n;
    logic [2:0] type_q, type_n;
    logic [1:0] dur, dur_n;
    logic [4:0] valve_n;
    logic       rej_n, abt_n;
    logic       in_ingr;
    logic       expire, clear;

    assign in_ingr = (state >= ST_WATER) && (state <= ST_CHOC);
    assign dur     = recipe_dur(type_q, 3'(state) - 3'd1);
    assign clear   = (state_n != state);

    step_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .enable(in_ingr),
        .target(dur),
        .expire(expire)
    );

    // Next state, latched type and event flags; abort outranks expiry.
    always_comb begin
        state_n = state;
        type_n  = type_q;
        rej_n   = 1'b0;
        abt_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (paid && ({1'b0, coffee_type} < TYPE_LIMIT)) begin
                        type_n  = coffee_type;
                        state_n = ST_WATER;
                    end else begin
                        rej_n = 1'b1;
                    end
                end
            end
            ST_WATER, ST_COFFEE, ST_SUGAR, ST_MILK, ST_CHOC: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    abt_n   = 1'b1;
                end else if (expire) begin
                    state_n = state_t'(3'(state) + 3'd1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they can be registered
    // while still lining up with the state they describe.
    always_comb begin
        dur_n   = recipe_dur(type_n, 3'(state_n) - 3'd1);
        valve_n = '0;
        if (dur_n != 2'd0) begin
            case (state_n)
                ST_WATER:  valve_n = 5'b10000;
                ST_COFFEE: valve_n = 5'b01000;
                ST_SUGAR:  valve_n = 5'b00100;
                ST_MILK:   valve_n = 5'b00010;
                ST_CHOC:   valve_n = 5'b00001;
                default:   valve_n = '0;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            type_q    <= '0;
            ready     <= 1'b1;
            water     <= 1'b0;
            coffee    <= 1'b0;
            sugar     <= 1'b0;
            milk      <= 1'b0;
            chocolate <= 1'b0;
            step      <= '0;
            finished  <= 1'b0;
            rejected  <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            type_q    <= type_n;
            ready     <= (state_n == ST_IDLE);
            water     <= valve_n[4];
            coffee    <= valve_n[3];
            sugar     <= valve_n[2];
            milk      <= valve_n[1];
            chocolate <= valve_n[0];
            step      <= 3'(state_n);
            finished  <= (state_n == ST_DONE);
            rejected  <= rej_n;
            aborted   <= abt_n;
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer with TICKS_PER_SEC=4.
module tb_brew_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, paid, abort;
    logic [2:0] ctype;
    logic       ready, water, coffee, sugar, milk, chocolate;
    logic [2:0] step;
    logic       finished, rejected, aborted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brew_sequencer #(
        .TICKS_PER_SEC(4),
        .NUM_TYPES    (5)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .start      (start),
        .coffee_type(ctype),
        .paid       (paid),
        .abort      (abort),
        .ready      (ready),
        .water      (water),
        .coffee     (coffee),
        .sugar      (sugar),
        .milk       (milk),
        .chocolate  (chocolate),
        .step       (step),
        .finished   (finished),
        .rejected   (rejected),
        .aborted    (aborted)
    );

    typedef struct {
        logic       st;
        logic       pd;
        logic [2:0] ty;
        logic       ab;
        logic       rdy;
        logic [4:0] val;
        logic [2:0] stp;
        logic       fin;
        logic       rej;
        logic       abt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [4:0] W = 5'b10000, C = 5'b01000, S = 5'b00100,
                           M = 5'b00010, H = 5'b00001, Z = 5'b00000;

    task automatic add(input int n, input logic st, input logic pd, input logic [2:0] ty,
                       input logic ab, input logic rdy, input logic [4:0] val,
                       input logic [2:0] stp, input logic fin, input logic rej, input logic abt);
        vec_t v;
        v.st = st; v.pd = pd; v.ty = ty; v.ab = ab; v.rdy = rdy; v.val = val;
        v.stp = stp; v.fin = fin; v.rej = rej; v.abt = abt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] outs();
        return {ready, water, coffee, sugar, milk, chocolate, step, finished, rejected, aborted};
    endfunction

    initial begin
        int cw, cc, cs, cm, ch, cf, multi, n;
        start = 0; paid = 0; abort = 0; ctype = 0;
        rst_n = 0;

        // espresso 1,2,0,0,0
        add(1, 1,1,0,0, 0,W,1,0,0,0);
        add(3, 0,0,0,0, 0,W,1,0,0,0);
        add(8, 0,0,0,0, 0,C,2,0,0,0);
        add(1, 0,0,0,0, 0,Z,3,0,0,0);
        add(1, 0,0,0,0, 0,Z,4,0,0,0);
        add(1, 0,0,0,0, 0,Z,5,0,0,0);
        add(1, 0,0,0,0, 0,Z,6,1,0,0);
        add(1, 0,0,0,0, 1,Z,0,0,0,0);
        // rejections and abort ignored in idle
        add(1, 1,0,0,0, 1,Z,0,0,1,0);
        add(1, 1,1,5,0, 1,Z,0,0,1,0);
        add(1, 1,1,7,0, 1,Z,0,0,1,0);
        add(1, 0,0,0,1, 1,Z,0,0,0,0);
        // mocha 1,1,1,2,2
        add(1, 1,1,3,0, 0,W,1,0,0,0);
        add(3, 0,0,0,0, 0,W,1,0,0,0);
        add(4, 0,0,0,0, 0,C,2,0,0,0);
        add(4, 0,0,0,0, 0,S,3,0,0,0);
        add(8, 0,0,0,0, 0,M,4,0,0,0);
        add(8, 0,0,0,0, 0,H,5,0,0,0);
        add(1, 0,0,0,0, 0,Z,6,1,0,0);
        add(1, 0,0,0,0, 1,Z,0,0,0,0);
        // abort on the same cycle the water step would expire
        add(1, 1,1,0,0, 0,W,1,0,0,0);
        add(2, 0,0,0,0, 0,W,1,0,0,0);
        add(1, 0,0,0,1, 1,Z,0,0,0,1);
        add(1, 0,0,0,0, 1,Z,0,0,0,0);
        // americano with start held and type changed to 0 after accept
        add(1, 1,1,1,0, 0,W,1,0,0,0);
        add(11,1,1,0,0, 0,W,1,0,0,0);
        add(4, 1,1,0,0, 0,C,2,0,0,0);
        add(4, 1,1,0,0, 0,S,3,0,0,0);
        add(1, 1,1,0,0, 0,Z,4,0,0,0);
        add(1, 1,1,0,0, 0,Z,5,0,0,0);
        add(1, 1,1,0,0, 0,Z,6,1,0,0);
        add(1, 1,1,0,0, 1,Z,0,0,0,0);
        // restart latches espresso: 4 water cycles then coffee
        add(4, 1,1,0,0, 0,W,1,0,0,0);
        add(1, 1,1,0,0, 0,C,2,0,0,0);
        add(1, 0,0,0,1, 1,Z,0,0,0,1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'(12'b1_00000_000_000));
        rst_n = 1;
        #1;
        check("reset_release", 32'(outs()), 32'(12'b1_00000_000_000));
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; paid = vecs[i].pd; ctype = vecs[i].ty; abort = vecs[i].ab;
            tick();
            check($sformatf("row%0d", i), 32'(outs()),
                  32'({vecs[i].rdy, vecs[i].val, vecs[i].stp, vecs[i].fin, vecs[i].rej, vecs[i].abt}));
        end
        start = 0; paid = 0; abort = 0; ctype = 0;
        tick();

        // latte aborted during milk
        start = 1; paid = 1; ctype = 2;
        tick();
        start = 0; paid = 0; ctype = 7;
        n = 0;
        while (step != 3'd4 && n < 100) begin tick(); n++; end
        check("milk_reached", 32'(step), 32'd4);
        check("milk_valve", 32'({water, coffee, sugar, milk, chocolate}), 32'(M));
        tick();
        abort = 1;
        tick();
        check("abort_outs", 32'(outs()), 32'(12'b1_00000_000_001));
        abort = 0;
        tick();
        check("abort_pulse_end", 32'(outs()), 32'(12'b1_00000_000_000));

        // following cappuccino order runs normally: 1,2,0,2,1
        start = 1; paid = 1; ctype = 4;
        tick();
        start = 0; paid = 0;
        cw = 0; cc = 0; cs = 0; cm = 0; ch = 0; cf = 0; multi = 0;
        for (int i = 0; i < 40; i++) begin
            cw += int'(water); cc += int'(coffee); cs += int'(sugar);
            cm += int'(milk); ch += int'(chocolate); cf += int'(finished);
            if ($countones({water, coffee, sugar, milk, chocolate}) > 1) multi++;
            tick();
        end
        check("capp_water",  32'(cw), 32'd4);
        check("capp_coffee", 32'(cc), 32'd8);
        check("capp_sugar",  32'(cs), 32'd0);
        check("capp_milk",   32'(cm), 32'd8);
        check("capp_choc",   32'(ch), 32'd4);
        check("capp_finish", 32'(cf), 32'd1);
        check("capp_onehot", 32'(multi), 32'd0);
        check("capp_ready",  32'(ready), 32'd1);

        // asynchronous reset mid-coffee
        start = 1; paid = 1; ctype = 0;
        tick();
        start = 0; paid = 0;
        n = 0;
        while (step != 3'd2 && n < 100) begin tick(); n++; end
        check("coffee_reached", 32'(coffee), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("async_valves", 32'({water, coffee, sugar, milk, chocolate}), 32'd0);
        check("async_step", 32'(step), 32'd0);
        #3;
        rst_n = 1;
        tick();
        check("post_reset", 32'(outs()), 32'(12'b1_00000_000_000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Controller that sequences one drink order through the ingredient valves: water, coffee, sugar, milk, chocolate.
- Accepts a paid order from the coin/selection datapath via a start/ready handshake and looks up per-ingredient durations in a fixed recipe table.
- Times each step with an internal one-second prescaler, drives exactly one valve at a time, then reports completion.
- Replaces the separate general timer, per-coffee time lookup, time comparator and output FSM with one sequenced block.

Parameters:
- TICKS_PER_SEC, 50_000_000, clock cycles per one-second recipe unit (benches use 4).
- NUM_TYPES, 5, number of valid coffee_type codes (0..NUM_TYPES-1).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  order request; sampled only in IDLE.
- coffee_type  in  3  drink code, captured on accept.
- paid  in  1  payment sufficient (from the subtractor enable); required for accept.
- abort  in  1  cancel the running order.
- ready  out  1  high only in IDLE.
- water, coffee, sugar, milk, chocolate  out  1 each  valve drives, at most one high.
- step  out  3  current step index for display: 0 idle, 1..5 ingredient, 6 done.
- finished  out  1  one-cycle pulse on normal completion.
- rejected  out  1  one-cycle pulse when start arrives with an invalid type or !paid.
- aborted  out  1  one-cycle pulse when abort cancels an order.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, prescaler 0, second counter 0.
  - Captured type 0; step 0.
  - All valves 0; finished, rejected and aborted 0; ready 1 once reset releases.
- States: IDLE, WATER, COFFEE, SUGAR, MILK, CHOC, DONE. Ingredient order is fixed.
- IDLE:
  - If start=1, paid=1 and coffee_type<NUM_TYPES: latch the type and go to WATER next cycle; ready drops that cycle.
  - If start=1 otherwise: rejected pulses next cycle; stay in IDLE.
  - abort is ignored in IDLE.
- Recipe durations in seconds (2-bit, 0..3), listed as W,C,S,M,Ch:
  - type0 espresso: 1,2,0,0,0
  - type1 americano: 3,1,1,0,0
  - type2 latte: 1,1,1,3,0
  - type3 mocha: 1,1,1,2,2
  - type4 cappuccino: 1,2,0,2,1
- Ingredient step timing:
  - The valve for the step is high for exactly d*TICKS_PER_SEC cycles.
  - The prescaler and second counter clear on step entry.
  - When the second counter reaches d at a prescaler wrap, move to the next step.
- Zero-duration step: occupies exactly one cycle with all valves low, then advances.
- Step chain: CHOC is followed by DONE. DONE lasts one cycle, pulses finished=1 and step=6, then returns to IDLE.
- abort=1 in any ingredient state:
  - Next cycle: valves 0, aborted pulses, state IDLE.
  - abort takes priority over a step transition in the same cycle.
- start in non-IDLE states is ignored; no queuing.
- coffee_type changes after accept have no effect; the latched type governs.
- Mid-operation reset forces all valves low asynchronously.
- Counter widths:
  - Prescaler: $clog2(TICKS_PER_SEC) bits, wraps at TICKS_PER_SEC-1.
  - Second counter: 2 bits, never exceeds 3.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package brew_pkg:
  - state enum.
  - Ingredient index constants.
  - Recipe duration table as a constant array [NUM_TYPES][5] of 2-bit values.
  - STEP_DONE=6.
- Sub-module step_timer:
  - Inputs: clear, enable, target seconds.
  - Contains the prescaler and second counter.
  - Outputs a one-cycle expire strobe.
  - Parameterized by TICKS_PER_SEC.

Test Plan:
- TICKS_PER_SEC=4, start+paid, type0 -> water high for 4 cycles, coffee for 8, then 3 single-cycle skip steps (all valves low), finished pulse 1 cycle; ready returns 1.
- type3 -> durations 4,4,4,8,8 cycles in order W,C,S,M,Ch; at most one valve high every cycle; step output walks 1..6.
- start with paid=0, or with coffee_type=5 -> rejected pulse, ready stays 1, no valve activity.
- abort asserted during MILK of type2 -> valves 0 next cycle, aborted pulse, IDLE; a following order runs normally.
- reset driven low mid-COFFEE, asynchronously between edges -> valves drop before next edge; after release the block is in IDLE with all outputs at reset values.
- start held high through a full order and coffee_type changed mid-order -> exactly one order per IDLE entry; durations follow the latched type; back-to-back restart begins the cycle after DONE.
